mfcc_frame_buffer: RTL and testbench
====================================

MFCC_FRAME_BUFFER -- requirements
Module: mfcc_frame_buffer

Interface
REQ-001 Parameter NUM_FRAMES, default 4, SHALL set frame slots in the ring buffer (power of two, 2..16).
REQ-002 Parameter MAX_COEFFS, default 16, SHALL set coefficient slots per frame.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mfcc_in  input  32  MFCC coefficient from the accelerator output stream.
REQ-007 mfcc_valid  input  1  mfcc_in valid this cycle; no backpressure toward the producer.
REQ-008 num_mfcc_coeffs  input  8  coefficients per frame; sampled at frame start.
REQ-009 rd_data  output  32  coefficient presented to the consumer.
REQ-010 rd_valid  output  1  rd_data valid.
REQ-011 rd_ready  input  1  consumer accepts rd_data.
REQ-012 rd_last  output  1  rd_data is the final coefficient of its frame.
REQ-013 frames_avail  output  5  complete, unread or partly read frames held.
REQ-014 overflow  output  1  sticky; a frame was dropped.
REQ-015 dropped_frames  output  8  saturating count of dropped frames.

Function
REQ-016 Write side SHALL keep wr_idx (coefficient index) and wr_slot (frame slot); each mfcc_valid cycle stores mfcc_in at mem[wr_slot][wr_idx] unless the frame is being dropped.
REQ-017 On the first coefficient of a frame (wr_idx==0), frame length SHALL be latched as num_mfcc_coeffs clamped to 1..MAX_COEFFS (0 -> 1, >MAX_COEFFS -> MAX_COEFFS) and stored per slot.
REQ-018 Frame completes on the coefficient where wr_idx == latched length-1; wr_idx returns to 0, wr_slot increments modulo NUM_FRAMES, frames_avail increments the following cycle.
REQ-019 If frames_avail == NUM_FRAMES at a frame's first coefficient, the whole frame SHALL be dropped (no memory write, wr_slot unchanged) even if space frees mid-frame; at its last coefficient overflow sets and dropped_frames increments, saturating at 255.
REQ-020 Read FSM states: IDLE, LOAD, STREAM.
REQ-021 IDLE -> LOAD when frames_avail > 0; LOAD (one cycle) loads rd_data <= mem[rd_slot][0], rd_idx <= 0, -> STREAM.
REQ-022 STREAM: rd_valid = 1; rd_last = 1 iff rd_idx == stored length of rd_slot minus 1.
REQ-023 Handshake (rd_valid & rd_ready) not last: rd_idx++, rd_data <= next coefficient in the same edge; back-to-back transfers SHALL sustain one per cycle.
REQ-024 Handshake on last: rd_slot increments modulo NUM_FRAMES, frames_avail decrements, FSM -> IDLE (minimum one-cycle bubble plus LOAD between frames).
REQ-025 rd_data, rd_last SHALL hold stable while rd_valid & !rd_ready.
REQ-026 Frame completion and last-read handshake in the same cycle SHALL leave frames_avail unchanged.
REQ-027 A slot SHALL remain counted in frames_avail until its last coefficient is accepted, so the writer never overwrites a slot being read.
REQ-028 First-in first-out frame order; coefficient order within a frame preserved.

Reset
REQ-029 rst SHALL clear wr_idx, wr_slot, rd_slot, rd_idx, frames_avail=0, overflow=0, dropped_frames=0, rd_data=0, rd_valid=0, rd_last=0, FSM=IDLE; memory contents need not clear.
REQ-030 rst mid-frame or mid-read SHALL discard partial write and read state; first mfcc_valid after reset is coefficient 0 of a new frame.

Verification
REQ-031 num_mfcc_coeffs=13, 13 coefficients 1..13, rd_ready=1 -> rd_data 1..13 on consecutive cycles, rd_last only with 13, frames_avail 1->0.
REQ-032 NUM_FRAMES=4, 5 frames of 4 coefficients, rd_ready=0 -> frames_avail=4, overflow=1, dropped_frames=1; reading returns frames 1-4 intact.
REQ-033 rd_ready toggled 1,0,0,1 during a frame -> rd_data held during stalls, no loss or duplication.
REQ-034 num_mfcc_coeffs=0 then 200 (MAX_COEFFS=16) -> frames of length 1 and 16 respectively.
REQ-035 Frame completion in same cycle as last-read handshake with frames_avail=2 -> frames_avail stays 2.
REQ-036 rst asserted after 5 of 13 coefficients, then new 13-coefficient frame -> only new frame read out, overflow=0.

Source files
------------

// File: rtl/mfcc_frame_buffer.sv
// Ring buffer of MFCC frames between the accelerator output stream
// and a valid/ready consumer; whole frames are dropped when full.
module mfcc_frame_buffer #(
  parameter int NUM_FRAMES = 4,
  parameter int MAX_COEFFS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mfcc_in,
  input  logic        mfcc_valid,
  input  logic [7:0]  num_mfcc_coeffs,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic [4:0]  frames_avail,
  output logic        overflow,
  output logic [7:0]  dropped_frames
);

  localparam int SW = $clog2(NUM_FRAMES);
  localparam int CW = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;
  localparam int LW = CW + 1;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_COEFFS);
  localparam logic [7:0]    MAX_N8  = 8'(MAX_COEFFS);
  localparam logic [4:0]    FULL    = 5'(NUM_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_e;

  logic [31:0]   mem_q [NUM_FRAMES][MAX_COEFFS];
  logic [LW-1:0] len_q [NUM_FRAMES];

  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic [SW-1:0] wr_slot_q, wr_slot_d;
  logic [LW-1:0] wr_len_q, wr_len_d;
  logic          drop_q, drop_d;
  logic [4:0]    avail_q, avail_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  state_e        state_q, state_d;
  logic [SW-1:0] rd_slot_q, rd_slot_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          first;
  logic [LW-1:0] clamp_len;
  logic [LW-1:0] cur_len;
  logic          cur_drop;
  logic          frame_end;
  logic          mem_we;
  logic          len_we;
  logic          wr_done;
  logic          rd_done;
  logic [LW-1:0] rd_len;
  logic          rd_at_last;

  // Write side: latch length at frame start, decide drop, advance indices
  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_slot_d  = wr_slot_q;
    wr_len_d   = wr_len_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    mem_we     = 1'b0;
    len_we     = 1'b0;
    wr_done    = 1'b0;
    first      = (wr_idx_q == '0);
    if (num_mfcc_coeffs == 8'd0) begin
      clamp_len = LW'(1);
    end else if (num_mfcc_coeffs > MAX_N8) begin
      clamp_len = MAX_LEN;
    end else begin
      clamp_len = LW'(num_mfcc_coeffs);
    end
    cur_len   = first ? clamp_len : wr_len_q;
    cur_drop  = first ? (avail_q == FULL) : drop_q;
    frame_end = ({1'b0, wr_idx_q} == cur_len - LW'(1));
    if (mfcc_valid) begin
      wr_len_d = cur_len;
      drop_d   = cur_drop;
      mem_we   = !cur_drop;
      len_we   = first && !cur_drop;
      if (frame_end) begin
        wr_idx_d = '0;
        if (cur_drop) begin
          ovf_d = 1'b1;
          if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end else begin
          wr_slot_d = wr_slot_q + SW'(1);
          wr_done   = 1'b1;
        end
      end else begin
        wr_idx_d = wr_idx_q + CW'(1);
      end
    end
  end

  assign rd_len     = len_q[rd_slot_q];
  assign rd_at_last = ({1'b0, rd_idx_q} == rd_len - LW'(1));

  // Read FSM next state: fetch coefficient 0, then stream one per handshake
  always_comb begin
    state_d   = state_q;
    rd_slot_d = rd_slot_q;
    rd_idx_d  = rd_idx_q;
    rd_data_d = rd_data_q;
    rd_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail_q != 5'd0) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        rd_data_d = mem_q[rd_slot_q][CW'(0)];
        rd_idx_d  = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (rd_ready) begin
          if (rd_at_last) begin
            rd_slot_d = rd_slot_q + SW'(1);
            rd_done   = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_idx_d  = rd_idx_q + CW'(1);
            rd_data_d = mem_q[rd_slot_q][rd_idx_q + CW'(1)];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: a slot stays counted until its last coefficient is taken
  always_comb begin
    avail_d = avail_q + {4'b0, wr_done} - {4'b0, rd_done};
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q   <= '0;
      wr_slot_q  <= '0;
      wr_len_q   <= '0;
      drop_q     <= 1'b0;
      avail_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= IDLE;
      rd_slot_q  <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_slot_q  <= wr_slot_d;
      wr_len_q   <= wr_len_d;
      drop_q     <= drop_d;
      avail_q    <= avail_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      rd_slot_q  <= rd_slot_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Frame storage and per-slot lengths; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_slot_q][wr_idx_q] <= mfcc_in;
    end
    if (len_we) begin
      len_q[wr_slot_q] <= cur_len;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = (state_q == STREAM);
  assign rd_last        = rd_valid && rd_at_last;
  assign frames_avail   = avail_q;
  assign overflow       = ovf_q;
  assign dropped_frames = drop_cnt_q;

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Scoreboard bench for mfcc_frame_buffer: directed frames in,
// monitor compares every presented coefficient with the queue head.
module tb_mfcc_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mfcc_in;
  logic        mfcc_valid;
  logic [7:0]  num_mfcc_coeffs;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic [4:0]  frames_avail;
  logic        overflow;
  logic [7:0]  dropped_frames;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  mfcc_frame_buffer #(.NUM_FRAMES(4), .MAX_COEFFS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .mfcc_in         (mfcc_in),
    .mfcc_valid      (mfcc_valid),
    .num_mfcc_coeffs (num_mfcc_coeffs),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_last         (rd_last),
    .frames_avail    (frames_avail),
    .overflow        (overflow),
    .dropped_frames  (dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficients after the first carry a bogus count to prove latching
  task automatic send_frame(input logic [31:0] base, input logic [7:0] n_cfg,
                            input int count, input int exp_len,
                            input bit keep);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      mfcc_valid      = 1'b1;
      mfcc_in         = base + 32'(i);
      num_mfcc_coeffs = (i == 0) ? n_cfg : 8'd2;
      if (keep) begin
        e.d = base + 32'(i);
        e.l = (i == exp_len - 1);
        exp_q.push_back(e);
      end
      tick();
    end
    mfcc_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rd_valid && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(rd_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && frames_avail == 5'd0 && !rd_valid)
           && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every presented coefficient must match the queue head
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_output: got %h expected none", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q[0].d);
        check("rd_last", 32'(rd_last), 32'(exp_q[0].l));
        if (rd_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   cnt;
    rst             = 1'b1;
    mfcc_in         = '0;
    mfcc_valid      = 1'b0;
    num_mfcc_coeffs = '0;
    rd_ready        = 1'b0;
    tick();
    tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_avail", 32'(frames_avail), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dropped", 32'(dropped_frames), 32'd0);
    rst = 1'b0;
    tick();

    // 13-coefficient frame streamed back-to-back
    rd_ready = 1'b1;
    send_frame(32'd1, 8'd13, 13, 13, 1'b1);
    check("f13_avail_1", 32'(frames_avail), 32'd1);
    wait_valid("f13_valid");
    cnt = 0;
    while (!(rd_valid && rd_last) && cnt < 40) begin
      tick();
      cnt++;
    end
    check("f13_cycles", 32'(cnt), 32'd12);
    tick();
    check("f13_avail_0", 32'(frames_avail), 32'd0);
    wait_drain("f13_drain");

    // Stalls 1,0,0,1 while streaming a 4-coefficient frame
    rd_ready = 1'b0;
    send_frame(32'h100, 8'd4, 4, 4, 1'b1);
    wait_valid("stall_valid");
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    tick();
    rd_ready = 1'b1;
    wait_drain("stall_drain");

    // Length clamping: 0 -> 1, 200 -> 16
    send_frame(32'hA0, 8'd0, 1, 1, 1'b1);
    send_frame(32'hB0, 8'd200, 16, 16, 1'b1);
    wait_drain("clamp_drain");

    // Five frames into four slots: fifth is dropped
    rd_ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      send_frame(32'h1000 + 32'(f * 16), 8'd4, 4, 4, (f < 4));
    end
    check("ovf_avail", 32'(frames_avail), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_dropped", 32'(dropped_frames), 32'd1);
    rd_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Completion and last-read handshake in the same cycle
    rd_ready = 1'b0;
    send_frame(32'h200, 8'd2, 2, 2, 1'b1);
    send_frame(32'h210, 8'd2, 2, 2, 1'b1);
    wait_valid("same_valid");
    check("same_avail_pre", 32'(frames_avail), 32'd2);
    rd_ready = 1'b1;
    tick();
    rd_ready        = 1'b1;
    mfcc_valid      = 1'b1;
    mfcc_in         = 32'h220;
    num_mfcc_coeffs = 8'd1;
    e.d = 32'h220;
    e.l = 1'b1;
    exp_q.push_back(e);
    tick();
    mfcc_valid = 1'b0;
    rd_ready   = 1'b0;
    check("same_avail_post", 32'(frames_avail), 32'd2);
    rd_ready = 1'b1;
    wait_drain("same_drain");

    // Reset mid-frame discards the partial frame and clears overflow
    send_frame(32'h300, 8'd13, 5, 13, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_avail", 32'(frames_avail), 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_dropped", 32'(dropped_frames), 32'd0);
    send_frame(32'h400, 8'd13, 13, 13, 1'b1);
    wait_drain("mrst_drain");
    check("mrst_overflow_end", 32'(overflow), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
